// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID latch, prediction redirect and flush drain
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] fetch_pc,
   input  logic        fetch_predict,
   input  logic [31:0] fetch_target,
   input  logic        mem_flush,
   input  logic [31:0] mem_redirect_pc,
   input  logic        stall,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_predict,
   output logic [31:0] if_pred_target
);

   typedef enum logic {S_FETCH, S_DRAIN} state_t;

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_pc;
   logic [31:0] r_drain_addr;
   logic        r_if_valid;
   logic [31:0] r_if_instr;
   logic [31:0] r_if_pc;
   logic        r_if_predict;
   logic [31:0] r_if_pred_target;

   logic        w_accept;
   logic        w_outstanding;
   logic [31:0] w_target_aligned;
   logic [31:0] w_redirect_aligned;

   assign w_target_aligned   = fetch_target & ALIGN_MASK;
   assign w_redirect_aligned = mem_redirect_pc & ALIGN_MASK;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // In DRAIN the abandoned request is held until memory completes it, then dropped.
   always_comb begin
      w_next_state  = r_state;
      imem_req      = 1'b0;
      imem_addr     = r_pc;
      w_accept      = 1'b0;
      w_outstanding = 1'b0;
      case (r_state)
         S_FETCH: begin
            imem_req      = !rst && (!r_if_valid || !stall);
            w_outstanding = imem_req && !imem_ready;
            w_accept      = imem_req && imem_ready && !mem_flush;
            if (mem_flush && w_outstanding) begin
               w_next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            imem_req  = !rst;
            imem_addr = r_drain_addr;
            if (imem_ready) begin
               w_next_state = S_FETCH;
            end
         end
         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc             <= RESET_PC & ALIGN_MASK;
         r_drain_addr     <= 32'h0;
         r_if_valid       <= 1'b0;
         r_if_instr       <= 32'h0;
         r_if_pc          <= 32'h0;
         r_if_predict     <= 1'b0;
         r_if_pred_target <= 32'h0;
      end else if (mem_flush) begin
         r_if_valid <= 1'b0;
         r_pc       <= w_redirect_aligned;
         if (r_state == S_FETCH && w_outstanding) begin
            r_drain_addr <= r_pc;
         end
      end else if (w_accept) begin
         r_if_valid       <= 1'b1;
         r_if_instr       <= imem_rdata;
         r_if_pc          <= r_pc;
         r_if_predict     <= fetch_predict;
         r_if_pred_target <= w_target_aligned;
         r_pc             <= fetch_predict ? w_target_aligned : r_pc + 32'd4;
      end else if (!stall) begin
         r_if_valid <= 1'b0;
      end
   end

   assign fetch_pc       = r_pc;
   assign if_valid       = r_if_valid;
   assign if_instr       = r_if_instr;
   assign if_pc          = r_if_pc;
   assign if_predict     = r_if_predict;
   assign if_pred_target = r_if_pred_target;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - vector table, directed drain/reset sequences and randomized model check for fetch_unit
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] fetch_pc;
   logic        fetch_predict;
   logic [31:0] fetch_target;
   logic        mem_flush;
   logic [31:0] mem_redirect_pc;
   logic        stall;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_predict;
   logic [31:0] if_pred_target;

   int n_total;
   int n_pass;

   fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .fetch_pc        (fetch_pc),
      .fetch_predict   (fetch_predict),
      .fetch_target    (fetch_target),
      .mem_flush       (mem_flush),
      .mem_redirect_pc (mem_redirect_pc),
      .stall           (stall),
      .if_valid        (if_valid),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .if_predict      (if_predict),
      .if_pred_target  (if_pred_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        rdy;
      logic        pr;
      logic [31:0] tgt;
      logic        fl;
      logic [31:0] redir;
      logic        ereq;
      logic [31:0] eaddr;
      logic        ev;
      logic [31:0] einstr;
      logic [31:0] eifpc;
      logic        epr;
      logic [31:0] etgt;
   } vec_t;

   vec_t vecs[20];

   // Reference model: architectural view of the fetch stage
   logic [31:0] m_pc;
   bit          m_drain;
   logic [31:0] m_daddr;
   bit          m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_ifpc;
   bit          m_pred;
   logic [31:0] m_tgt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic rdy, input logic pr, input logic [31:0] tgt,
                        input logic fl, input logic [31:0] redir, input logic [31:0] rd);
      stall           = st;
      imem_ready      = rdy;
      fetch_predict   = pr;
      fetch_target    = tgt;
      mem_flush       = fl;
      mem_redirect_pc = redir;
      imem_rdata      = rd;
   endtask

   task automatic do_reset(input bit check);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      if (check) begin
         chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
         chk("rst_fetch_pc", fetch_pc, 32'h0);
         chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
         chk("rst_if_instr", if_instr, 32'h0);
         chk("rst_if_pc", if_pc, 32'h0);
         chk("rst_if_predict", {31'h0, if_predict}, 32'h0);
         chk("rst_if_pred_target", if_pred_target, 32'h0);
      end
      rst = 1'b0;
   endtask

   task automatic model_reset();
      m_pc    = 32'h0;
      m_drain = 0;
      m_daddr = 32'h0;
      m_valid = 0;
      m_instr = 32'h0;
      m_ifpc  = 32'h0;
      m_pred  = 0;
      m_tgt   = 32'h0;
   endtask

   task automatic model_step(input bit st, input bit rdy, input bit pr, input logic [31:0] tgt,
                             input bit fl, input logic [31:0] redir, input logic [31:0] rd);
      bit req;
      req = m_drain || !m_valid || !st;
      if (fl) begin
         if (m_drain) begin
            m_drain = !rdy;
         end else if (req && !rdy) begin
            m_drain = 1;
            m_daddr = m_pc;
         end
         m_valid = 0;
         m_pc    = {redir[31:2], 2'b00};
      end else if (m_drain) begin
         if (rdy) m_drain = 0;
      end else if (req && rdy) begin
         m_valid = 1;
         m_instr = rd;
         m_ifpc  = m_pc;
         m_pred  = pr;
         m_tgt   = {tgt[31:2], 2'b00};
         m_pc    = pr ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
      end else if (!st) begin
         m_valid = 0;
      end
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;

      //                st rdy pr  tgt            fl  redir      | req addr            v  instr          ifpc           pr  tgt
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h0000_0004, 1'b1, 32'hA000_0000, 32'h0,       1'b0, 32'h0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h0000_0008, 1'b1, 32'hA000_0001, 32'h4,       1'b0, 32'h0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h100,      1'b0, 32'h0,   1'b1, 32'h0000_000C, 1'b1, 32'hA000_0002, 32'h8,       1'b0, 32'h0};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h200,      1'b0, 32'h0,   1'b1, 32'h0000_0100, 1'b1, 32'hA000_0003, 32'hC,       1'b1, 32'h100};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0000_0200, 1'b1, 32'hA000_0004, 32'h100,     1'b1, 32'h200};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0000_0200, 1'b1, 32'hA000_0004, 32'h100,     1'b1, 32'h200};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0000_0200, 1'b1, 32'hA000_0004, 32'h100,     1'b1, 32'h200};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h0000_0200, 1'b1, 32'hA000_0004, 32'h100,     1'b1, 32'h200};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h0000_0204, 1'b1, 32'hA000_0008, 32'h200,     1'b0, 32'h0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h300, 1'b1, 32'h0000_0204, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h40,       1'b0, 32'h0,   1'b1, 32'h0000_0300, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h0000_0040, 1'b1, 32'hA000_000B, 32'h300,     1'b1, 32'h40};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h800, 1'b1, 32'h0000_0040, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h0000_0040, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h0000_0040, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h0000_0800, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
      vecs[17] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,  1'b1, 32'h0000_0804, 1'b1, 32'hA000_0010, 32'h800,     1'b0, 32'h0};
      vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'hFFFF_FFFC, 1'b1, 32'hA000_0011, 32'h804,     1'b1, 32'hFFFF_FFFC};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h0000_0000, 1'b1, 32'hA000_0012, 32'hFFFF_FFFC, 1'b0, 32'h0};

      do_reset(1'b1);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(vecs[i].st, vecs[i].rdy, vecs[i].pr, vecs[i].tgt, vecs[i].fl, vecs[i].redir,
               32'hA000_0000 + i);
         #1;
         chk($sformatf("vec%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].ereq});
         chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].eaddr);
         chk($sformatf("vec%0d_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].ev});
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d_instr", i), if_instr, vecs[i].einstr);
            chk($sformatf("vec%0d_ifpc", i), if_pc, vecs[i].eifpc);
            chk($sformatf("vec%0d_ifpred", i), {31'h0, if_predict}, {31'h0, vecs[i].epr});
            chk($sformatf("vec%0d_iftgt", i), if_pred_target, vecs[i].etgt);
         end
      end

      // Re-flush while draining, low redirect bits ignored, then reset mid-drain
      do_reset(1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 32'h0);
      #1;
      chk("drain_c0_addr", imem_addr, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h603, 32'h0);
      #1;
      chk("drain_c1_req", {31'h0, imem_req}, 32'h1);
      chk("drain_c1_addr", imem_addr, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF);
      #1;
      chk("drain_c2_addr", imem_addr, 32'h0);
      chk("drain_c2_valid", {31'h0, if_valid}, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("drain_c3_addr", imem_addr, 32'h600);
      chk("drain_c3_valid", {31'h0, if_valid}, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h900, 32'h0);
      #1;
      chk("drain_c4_addr", imem_addr, 32'h600);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("drain_c5_addr", imem_addr, 32'h600);
      rst = 1'b1;
      #1;
      chk("midrst_req", {31'h0, imem_req}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("postrst_req", {31'h0, imem_req}, 32'h1);
      chk("postrst_addr", imem_addr, 32'h0);
      chk("postrst_valid", {31'h0, if_valid}, 32'h0);

      // Randomized run against the reference model
      do_reset(1'b0);
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         bit          st, rdy, pr, fl;
         logic [31:0] tgt, redir, rd;
         bit          ereq;
         logic [31:0] eaddr;
         st    = ($urandom_range(0, 9) < 3);
         rdy   = ($urandom_range(0, 9) < 6);
         pr    = ($urandom_range(0, 3) == 0);
         fl    = ($urandom_range(0, 11) == 0);
         tgt   = {$urandom_range(0, 16'hFFFF), 16'h0} | ($urandom & 32'h0000_FFFF);
         redir = $urandom;
         rd    = $urandom;
         @(negedge clk);
         drive(st, rdy, pr, tgt, fl, redir, rd);
         #1;
         ereq  = m_drain || !m_valid || !st;
         eaddr = m_drain ? m_daddr : m_pc;
         chk("rnd_req", {31'h0, imem_req}, {31'h0, ereq});
         if (ereq) chk("rnd_addr", imem_addr, eaddr);
         if (!m_drain) chk("rnd_fetch_pc", fetch_pc, m_pc);
         chk("rnd_valid", {31'h0, if_valid}, {31'h0, m_valid});
         if (m_valid) begin
            chk("rnd_instr", if_instr, m_instr);
            chk("rnd_ifpc", if_pc, m_ifpc);
            chk("rnd_ifpred", {31'h0, if_predict}, {31'h0, m_pred});
            chk("rnd_iftgt", if_pred_target, m_tgt);
         end
         model_step(st, rdy, pr, tgt, fl, redir, rd);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have ports, one clock; reset is asynchronous and active-high:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- fetch_pc  out  32  current PC, to branch predictor
- fetch_predict  in  1  predictor says taken for fetch_pc
- fetch_target  in  32  predicted target for fetch_pc
- mem_flush  in  1  branch mispredict resolved in MEM; redirect
- mem_redirect_pc  in  32  correct next PC on mem_flush
- stall  in  1  decode cannot accept IF/ID contents
- if_valid  out  1  IF/ID latch holds an instruction
- if_instr  out  32  latched instruction
- if_pc  out  32  PC of latched instruction
- if_predict  out  1  prediction used for that instruction
- if_pred_target  out  32  predicted target used

Function
REQ-003 SHALL hold PC register pc; pc[1:0] always 0; fetch_target[1:0] and mem_redirect_pc[1:0] ignored.
REQ-004 SHALL drive fetch_pc = pc and imem_addr = pc combinationally in state FETCH; imem_addr = held drain address in state DRAIN.
REQ-005 SHALL implement two states: FETCH (normal) and DRAIN (discarding an abandoned request).
REQ-006 In FETCH, imem_req SHALL be 1 when (!if_valid || !stall) and not in reset; otherwise 0.
REQ-007 Once imem_req=1 with imem_ready=0, imem_req and imem_addr SHALL stay stable until imem_ready=1 (handshake rule), except as REQ-010.
REQ-008 Accept = FETCH && imem_req && imem_ready && !mem_flush: latch if_instr=imem_rdata, if_pc=pc, if_predict=fetch_predict, if_pred_target=fetch_target, if_valid=1; pc <= fetch_predict ? fetch_target : pc+4.
REQ-009 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-010 mem_flush SHALL have priority over all events: if_valid <= 0; pc <= mem_redirect_pc; any imem_rdata that cycle discarded.
REQ-011 mem_flush while a request is outstanding (imem_req=1, imem_ready=0) SHALL enter DRAIN: keep imem_req=1 and imem_addr = abandoned address until imem_ready=1, discard data, return to FETCH next cycle.
REQ-012 mem_flush during DRAIN SHALL update pc to the newest mem_redirect_pc and remain in DRAIN.
REQ-013 When if_valid=1 and stall=1 (no flush), IF/ID outputs SHALL hold unchanged.
REQ-014 When if_valid=1, stall=0, and no accept that cycle, if_valid SHALL clear to 0.
REQ-015 Fetch latency: instruction SHALL appear on IF/ID outputs the cycle after imem_ready=1.
REQ-016 With imem_ready=1 every cycle and stall=0, SHALL sustain one instruction per cycle.

Reset
REQ-017 While rst=1: pc=RESET_PC, state=FETCH, if_valid=0, if_instr=0, if_pc=0, if_predict=0, if_pred_target=0, imem_req=0.
REQ-018 Reset asserted mid-request or mid-DRAIN SHALL abandon the request immediately; first cycle after rst deasserts SHALL assert imem_req with imem_addr=RESET_PC.

Verification
REQ-019 Reset release, imem_ready=1 always, predict=0 -> imem_addr 0,4,8,12 on consecutive cycles; if_pc follows one cycle later.
REQ-020 pc=32'h100, fetch_predict=1, fetch_target=32'h200 -> next imem_addr=32'h200; if_predict=1, if_pred_target=32'h200 for if_pc=32'h100.
REQ-021 if_valid=1, stall=1 for 3 cycles -> IF/ID outputs unchanged, imem_req=0; stall drops -> fetch resumes at held pc.
REQ-022 Request to 32'h40 pending (imem_ready=0), mem_flush with mem_redirect_pc=32'h800 -> DRAIN, imem_addr stays 32'h40 until ready, data discarded, next request 32'h800, if_valid=0 throughout.
REQ-023 mem_flush and imem_ready=1 same cycle, redirect 32'h300 -> no instruction latched, if_valid=0, next imem_addr=32'h300.
REQ-024 pc=32'hFFFF_FFFC, predict=0, accept -> next imem_addr=32'h0000_0000.
